// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier.
// Optional accumulate path is selected with the BOOTH_ACCUM_EN macro.
package booth_pkg;

    typedef enum logic [2:0] {
        BD_ZERO,
        BD_P1,
        BD_M1,
        BD_P2,
        BD_M2
    } booth_digit_t;

`ifdef BOOTH_ACCUM_EN
    localparam bit ACCUM_EN = 1'b1;
`else
    localparam bit ACCUM_EN = 1'b0;
`endif

    function automatic int NDIG(input int w);
        return (w + 2) / 2;
    endfunction

    function automatic int PP_W(input int w);
        return 2 * w + 4;
    endfunction

    function automatic int out_width(input int w, input int guard);
        return ACCUM_EN ? (2 * w + guard) : (2 * w);
    endfunction

    function automatic booth_digit_t booth_decode(input logic [2:0] win);
        booth_digit_t d;
        case (win)
            3'b001, 3'b010: d = BD_P1;
            3'b011:         d = BD_P2;
            3'b100:         d = BD_M2;
            3'b101, 3'b110: d = BD_M1;
            default:        d = BD_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_mult_pipe_if.sv
// Operand/result handshake bundle for booth_mult_pipe; accumulate controls
// exist only when BOOTH_ACCUM_EN is defined.
interface booth_mult_pipe_if #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
`ifdef BOOTH_ACCUM_EN
    logic             in_acc;
    logic             in_acc_clr;
    logic             acc_ovf;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_signed, in_a, in_b, out_ready,
`ifdef BOOTH_ACCUM_EN
        output in_acc, in_acc_clr,
        input  acc_ovf,
`endif
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_signed, in_a, in_b, out_ready,
`ifdef BOOTH_ACCUM_EN
        input  in_acc, in_acc_clr,
        output acc_ovf,
`endif
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/booth_mult_pipe_pp_gen.sv
// Purpose: one Booth digit -> sign-extended partial product shifted by 2*IDX.
// Latency: combinational. Backpressure: none (pure function of inputs).
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX   = 0
) (
    input  logic [2:0]              win_i,
    input  logic [WIDTH+1:0]        a_ext_i,
    output logic [PP_W(WIDTH)-1:0]  pp_o
);
    localparam int PW = PP_W(WIDTH);

    logic [PW-1:0] a_pw;
    logic [PW-1:0] mag;

    assign a_pw = PW'($signed(a_ext_i));

    always_comb begin
        mag = '0;
        case (booth_decode(win_i))
            BD_P1:   mag = a_pw;
            BD_M1:   mag = -a_pw;
            BD_P2:   mag = a_pw << 1;
            BD_M2:   mag = -(a_pw << 1);
            default: mag = '0;
        endcase
    end

    assign pp_o = mag << (2 * IDX);
endmodule

// File: rtl/booth_mult_pipe.sv
// Purpose: radix-4 Booth multiplier, signed/unsigned per op; MAC when BOOTH_ACCUM_EN.
// Latency: 3 cycles accept->out_valid, 1 op/cycle. Backpressure: whole pipe stalls while out_valid & !out_ready.
module booth_mult_pipe
    import booth_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_GUARD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    booth_mult_pipe_if.slave bus
);
    localparam int EW  = WIDTH + 2;
    localparam int ND  = NDIG(WIDTH);
    localparam int PW  = PP_W(WIDTH);
    localparam int PRW = 2 * WIDTH;
    localparam int OW  = out_width(WIDTH, ACC_GUARD);

    logic          adv;
    logic          out_vld_q;
    logic [OW-1:0] out_data_q, out_data_d;

    assign adv          = !out_vld_q || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_vld_q;
    assign bus.out_data  = out_data_q;

    // S1: operand capture with mode-dependent extension to WIDTH+2
    logic          s1_vld_q, s1_sgn_q;
    logic [EW-1:0] s1_a_q, s1_b_q, s1_a_d, s1_b_d;
    logic          s2_vld_q, s2_sgn_q;
    logic [PRW-1:0] s2_sum_q, s2_car_q;
`ifdef BOOTH_ACCUM_EN
    logic          s1_acc_q, s1_clr_q, s2_acc_q, s2_clr_q;
`endif

    assign s1_a_d = bus.in_signed ? {{2{bus.in_a[WIDTH-1]}}, bus.in_a} : {2'b00, bus.in_a};
    assign s1_b_d = bus.in_signed ? {{2{bus.in_b[WIDTH-1]}}, bus.in_b} : {2'b00, bus.in_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_sgn_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
`ifdef BOOTH_ACCUM_EN
            s1_acc_q <= 1'b0;
            s1_clr_q <= 1'b0;
`endif
        end else if (adv) begin
            s1_vld_q <= bus.in_valid;
            s1_sgn_q <= bus.in_signed;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
`ifdef BOOTH_ACCUM_EN
            s1_acc_q <= bus.in_acc;
            s1_clr_q <= bus.in_acc_clr;
`endif
        end
    end

    // S2: Booth recoding of {b_ext, 0}, then carry-save reduction
    logic [EW:0]   bx;
    logic [PW-1:0] pp [ND];
    logic [PW-1:0] csa_s, csa_c, csa_t;
    logic          unused_csa_hi;

    assign bx = {s1_b_q, 1'b0};

    for (genvar i = 0; i < ND; i++) begin : g_pp
        booth_pp_gen #(.WIDTH(WIDTH), .IDX(i)) u_pp (
            .win_i   (bx[2*i+2 -: 3]),
            .a_ext_i (s1_a_q),
            .pp_o    (pp[i])
        );
    end

    always_comb begin
        csa_s = pp[0];
        csa_c = '0;
        csa_t = '0;
        for (int i = 1; i < ND; i++) begin
            csa_t = csa_s ^ csa_c ^ pp[i];
            csa_c = ((csa_s & csa_c) | (csa_s & pp[i]) | (csa_c & pp[i])) << 1;
            csa_s = csa_t;
        end
    end

    // Bits above 2*WIDTH only carry sign extension; the kept product never depends on them.
    assign unused_csa_hi = ^{csa_s[PW-1:PRW], csa_c[PW-1:PRW]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q <= 1'b0;
            s2_sgn_q <= 1'b0;
            s2_sum_q <= '0;
            s2_car_q <= '0;
`ifdef BOOTH_ACCUM_EN
            s2_acc_q <= 1'b0;
            s2_clr_q <= 1'b0;
`endif
        end else if (adv) begin
            s2_vld_q <= s1_vld_q;
            s2_sgn_q <= s1_sgn_q;
            s2_sum_q <= csa_s[PRW-1:0];
            s2_car_q <= csa_c[PRW-1:0];
`ifdef BOOTH_ACCUM_EN
            s2_acc_q <= s1_acc_q;
            s2_clr_q <= s1_clr_q;
`endif
        end
    end

    // S3: carry-propagate add, optional accumulate, into the output register
    logic [PRW-1:0] prod;
    logic [OW-1:0]  prod_ext;

    assign prod     = s2_sum_q + s2_car_q;
    assign prod_ext = s2_sgn_q ? OW'($signed(prod)) : OW'(prod);

`ifdef BOOTH_ACCUM_EN
    logic [OW-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d, ovf_add;
    logic [OW:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, prod_ext};
    assign ovf_add = s2_sgn_q ? ((acc_q[OW-1] == prod_ext[OW-1]) && (acc_sum[OW-1] != acc_q[OW-1]))
                              : acc_sum[OW];
    assign bus.acc_ovf = ovf_q;

    always_comb begin
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        out_data_d = prod_ext;
        if (s2_clr_q) begin
            acc_d      = prod_ext;
            ovf_d      = 1'b0;
            out_data_d = prod_ext;
        end else if (s2_acc_q) begin
            acc_d      = acc_sum[OW-1:0];
            ovf_d      = ovf_q || ovf_add;
            out_data_d = acc_sum[OW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (adv && s2_vld_q) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end
`else
    assign out_data_d = prod_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else if (adv) begin
            out_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                out_data_q <= out_data_d;
            end
        end
    end
endmodule

// File: tb/tb_booth_mult_pipe.sv
// Bench for booth_mult_pipe (WIDTH=8): directed literal vectors, back-pressure,
// mid-flight reset, random streams, and the MAC path when BOOTH_ACCUM_EN is defined.
module tb_booth_mult_pipe;
    import booth_pkg::*;

    localparam int W  = 8;
    localparam int G  = 4;
    localparam int OW = out_width(W, G);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_mult_pipe_if #(.WIDTH(W), .OUT_W(OW)) bus ();

    booth_mult_pipe #(.WIDTH(W), .ACC_GUARD(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        bit         sgn;
        bit         acc;
        bit         clr;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } txn_t;

    txn_t   q[$];
    txn_t   mon_t;
    longint acc_m = 0;
    bit     ovf_m = 1'b0;
    bit     stalled_q = 1'b0;
    logic [OW-1:0] held_q = '0;
    int     stalls = 0;
    bit     rnd_done = 1'b0;

    function automatic longint val(input bit s, input logic [W-1:0] x);
        return s ? longint'($signed(x)) : longint'(x);
    endfunction

    function automatic longint wrap(input longint v);
        logic [63:0] t;
        t = v;
        return longint'(t[OW-1:0]);
    endfunction

    function automatic longint ref_prod(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] t;
        t = val(s, a) * val(s, b);
        return longint'(t[2*W-1:0]);
    endfunction

    // Reference: true integer product, optional accumulate with range-based overflow.
    function automatic longint model_out(input txn_t t);
        longint p, cur, tot;
        logic [OW-1:0] pat;
        p = val(t.sgn, t.a) * val(t.sgn, t.b);
`ifdef BOOTH_ACCUM_EN
        if (t.clr) begin
            acc_m = wrap(p);
            ovf_m = 1'b0;
            return acc_m;
        end else if (t.acc) begin
            pat = acc_m[OW-1:0];
            cur = t.sgn ? longint'($signed(pat)) : longint'(pat);
            tot = cur + p;
            if (t.sgn) begin
                if (tot > ((64'sd1 <<< (OW-1)) - 1) || tot < -(64'sd1 <<< (OW-1))) ovf_m = 1'b1;
            end else if (tot >= (64'sd1 <<< OW)) begin
                ovf_m = 1'b1;
            end
            acc_m = wrap(tot);
            return acc_m;
        end
`else
        cur = 0; tot = 0; pat = '0;
        if (cur != tot || pat != '0) return 0;
`endif
        return wrap(p);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                mon_t.sgn = bus.in_signed;
                mon_t.a   = bus.in_a;
                mon_t.b   = bus.in_b;
`ifdef BOOTH_ACCUM_EN
                mon_t.acc = bus.in_acc;
                mon_t.clr = bus.in_acc_clr;
`else
                mon_t.acc = 1'b0;
                mon_t.clr = 1'b0;
`endif
                q.push_back(mon_t);
            end
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                check("in_ready_stall", longint'(bus.in_ready), 0);
            end
            if (stalled_q) check("hold", longint'(bus.out_data), longint'(held_q));
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    mon_t = q.pop_front();
                    check("out_data", longint'(bus.out_data), model_out(mon_t));
`ifdef BOOTH_ACCUM_EN
                    check("acc_ovf", longint'(bus.acc_ovf), longint'(ovf_m));
`endif
                end
            end
            stalled_q = bus.out_valid && !bus.out_ready;
            held_q    = bus.out_data;
        end else begin
            stalled_q = 1'b0;
        end
    end

    task automatic send(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit acc, input bit clr);
        int guard;
`ifndef BOOTH_ACCUM_EN
        bit unused_flags;
        unused_flags = acc ^ clr;
`endif
        guard = 0;
        bus.in_valid  = 1'b1;
        bus.in_signed = s;
        bus.in_a      = a;
        bus.in_b      = b;
`ifdef BOOTH_ACCUM_EN
        bus.in_acc     = acc;
        bus.in_acc_clr = clr;
`endif
        @(negedge clk);
        while (!bus.in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic directed(input string nm, input bit s, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit acc, input bit clr,
                            input logic [2*W-1:0] lit);
        int cyc;
        cyc = 0;
        send(s, a, b, acc, clr);
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.out_valid && cyc < 20);
        check({nm, "_lat"}, cyc, 3);
        check(nm, longint'(bus.out_data[2*W-1:0]), longint'(lit));
        @(posedge clk); #1;
    endtask

    task automatic drain(input string nm);
        int g;
        g = 0;
        while (q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check({nm, "_drain"}, q.size(), 0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit           s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs[10] = '{
        '{1'b1, 8'h80, 8'h80, 16'h4000},
        '{1'b1, 8'hFF, 8'h02, 16'hFFFE},
        '{1'b0, 8'hFF, 8'hFF, 16'hFE01},
        '{1'b0, 8'h80, 8'h03, 16'h0180},
        '{1'b1, 8'h7F, 8'h80, 16'hC080},
        '{1'b1, 8'hFF, 8'hFF, 16'h0001},
        '{1'b0, 8'hFF, 8'h02, 16'h01FE},
        '{1'b1, 8'h80, 8'h7F, 16'hC080},
        '{1'b1, 8'h80, 8'h01, 16'hFF80},
        '{1'b0, 8'h00, 8'hAB, 16'h0000}
    };

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_signed = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
`ifdef BOOTH_ACCUM_EN
        bus.in_acc     = 1'b0;
        bus.in_acc_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_data", longint'(bus.out_data), 0);
`ifdef BOOTH_ACCUM_EN
        check("rst_acc_ovf", longint'(bus.acc_ovf), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            check($sformatf("model_pin%0d", i), ref_prod(vecs[i].s, vecs[i].a, vecs[i].b),
                  longint'(vecs[i].p));
            directed($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, 1'b0, 1'b0, vecs[i].p);
        end
        drain("directed");

        // Six back-to-back ops with out_ready low for four cycles
        stalls = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(i[0], W'(8'h11 * (i + 1)), W'(8'hF0 - 8'h13 * i), 1'b0, 1'b0);
            end
            begin
                repeat (3) begin @(posedge clk); #1; end
                bus.out_ready = 1'b0;
                repeat (4) begin @(posedge clk); #1; end
                bus.out_ready = 1'b1;
            end
        join
        drain("bp");
        check("bp_stall_seen", longint'(stalls > 0), 1);

        // Reset with three ops in flight
        send(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        send(1'b0, 8'hA5, 8'h5A, 1'b0, 1'b0);
        send(1'b1, 8'h80, 8'h7F, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(bus.out_valid), 0);
        q.delete();
        acc_m = 0;
        ovf_m = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        directed("post_rst", 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 16'h03A8);
        drain("post_rst");

        // Random streams with bubbles and random back-pressure, both modes
        for (int m = 0; m < 2; m++) begin
            rnd_done = 1'b0;
            fork
                begin
                    for (int n = 0; n < 10000; n++) begin
                        if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
                        send(m[0], W'($urandom), W'($urandom), 1'b0, 1'b0);
                    end
                    rnd_done = 1'b1;
                end
                begin
                    while (!rnd_done) begin
                        @(posedge clk); #1;
                        bus.out_ready = ($urandom_range(0, 3) != 0);
                    end
                    bus.out_ready = 1'b1;
                end
            join
            drain($sformatf("rnd%0d", m));
        end

`ifdef BOOTH_ACCUM_EN
        directed("mac_clr", 1'b1, 8'd100, 8'd100, 1'b0, 1'b1, 16'd10000);
        directed("mac_acc", 1'b1, 8'd100, 8'd100, 1'b1, 1'b0, 16'd20000);
        for (int i = 0; i < 32; i++) send(1'b1, 8'h80, 8'h80, 1'b1, 1'b0);
        drain("mac_wrap");
        @(negedge clk);
        check("mac_ovf_set", longint'(bus.acc_ovf), 1);
        @(posedge clk); #1;
        directed("mac_clr2", 1'b1, 8'd100, 8'd100, 1'b1, 1'b1, 16'd10000);
        check("mac_ovf_clr", longint'(bus.acc_ovf), 0);
        drain("mac");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
